// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The master side issues operations; the slave side is the sequencer.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, op_a, op_b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one shared NAND full adder, one bit per
// clock LSB first, with start/busy/done handshake and registered results.
module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic n1, n2, n3, x1, n4, n5, n6;

    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign x1   = ~(n2 & n3);
    assign n4   = ~(x1 & cin);
    assign n5   = ~(x1 & n4);
    assign n6   = ~(cin & n4);
    assign s    = ~(n5 & n6);
    assign cout = ~(n4 & n1);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               fa_s, fa_cout;

    full_adder_nand u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.op_a;
                    b_sh_d  = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                // Results commit on the same edge that enters DONE; carry_q
                // here is the carry into the MSB, so no separate latch is kept.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = s_sh_d;
                    cout_d  = fa_cout;
                    ovf_d   = fa_cout ^ carry_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): reset, add/sub vectors,
// start-while-busy, back-to-back operation and reset mid-operation.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       c;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    // Issues one operation and waits (bounded) for done; returns the cycle
    // index of done relative to the start-sampling edge and busy-cycle count.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c,
                         output int done_cyc, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = 8'hA5;
        bus.op_b  = 8'h5A;
        bus.sub   = ~s;
        bus.cin   = ~c;
        done_cyc  = 1;
        busy_cnt  = 0;
        while (!bus.done && done_cyc < 30) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            done_cyc++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op_a  = 8'h12;
        bus.op_b  = 8'h34;
        bus.cin   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_add_sub();
        vec_t v[5];
        int   dc, bc;
        v[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        v[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        v[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        v[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        v[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, v[i].c, dc, bc);
            checks++; if (dc !== 9) begin errors++; $display("FAIL op%0d_done_cycle: got %0d want 9", i, dc); end
            checks++; if (bc !== 8) begin errors++; $display("FAIL op%0d_busy_cycles: got %0d want 8", i, bc); end
            checks++; if (bus.sum !== v[i].es) begin errors++; $display("FAIL op%0d_sum: got %h want %h", i, bus.sum, v[i].es); end
            checks++; if (bus.cout !== v[i].ec) begin errors++; $display("FAIL op%0d_cout: got %b want %b", i, bus.cout, v[i].ec); end
            checks++; if (bus.ovf !== v[i].eo) begin errors++; $display("FAIL op%0d_ovf: got %b want %b", i, bus.ovf, v[i].eo); end
            @(negedge clk);
            checks++; if (bus.done !== 1'b0 || bus.sum !== v[i].es) begin
                errors++; $display("FAIL op%0d_after_done: done=%b sum=%h want done=0 sum=%h", i, bus.done, bus.sum, v[i].es);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n_done   = 0;
        int done_cyc = 0;
        logic [7:0] s_at = 8'h00;
        logic       o_at = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 3) begin
                bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01; bus.sub = 1'b1;
            end
            if (cyc == 4) bus.start = 1'b0;
            if (bus.done) begin
                n_done++; done_cyc = cyc; s_at = bus.sum; o_at = bus.ovf;
            end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL ign_done_cycle: got %0d want 9", done_cyc); end
        checks++; if (s_at !== 8'h96) begin errors++; $display("FAIL ign_sum: got %h want 96", s_at); end
        checks++; if (o_at !== 1'b1) begin errors++; $display("FAIL ign_ovf: got %b want 1", o_at); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0, first = 0, second = 0;
        bit stable = 1'b1;
        logic [7:0] s19 = 8'hAA;
        logic       c19 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin bus.op_a = 8'hFF; bus.op_b = 8'h01; end
            if (bus.done) begin
                if (n_done == 0) first = cyc;
                else if (n_done == 1) begin second = cyc; s19 = bus.sum; c19 = bus.cout; end
                n_done++;
            end
            if (cyc >= 10 && cyc <= 18 &&
                (bus.sum !== 8'h96 || bus.cout !== 1'b0 || bus.ovf !== 1'b1)) stable = 1'b0;
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        checks++; if (first !== 9) begin errors++; $display("FAIL b2b_first_done: got %0d want 9", first); end
        checks++; if (second !== 19) begin errors++; $display("FAIL b2b_second_done: got %0d want 19", second); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_stable: got %b want 1", stable); end
        checks++; if (s19 !== 8'h00) begin errors++; $display("FAIL b2b_second_sum: got %h want 00", s19); end
        checks++; if (c19 !== 1'b1) begin errors++; $display("FAIL b2b_second_cout: got %b want 1", c19); end
    endtask

    task automatic test_reset_mid_run();
        int dc, bc;
        int n_done = 0;
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, dc, bc);
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.sum !== 8'h96) begin
            errors++; $display("FAIL mid_pre_reset: busy=%b sum=%h want busy=1 sum=96", bus.busy, bus.sum);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", bus.done); end
        checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL mid_sum: got %h want 00", bus.sum); end
        checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL mid_flags: cout=%b ovf=%b want 0 0", bus.cout, bus.ovf);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", n_done); end
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, dc, bc);
        checks++; if (dc !== 9) begin errors++; $display("FAIL post_done_cycle: got %0d want 9", dc); end
        checks++; if (bus.sum !== 8'h80) begin errors++; $display("FAIL post_sum: got %h want 80", bus.sum); end
        checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
            errors++; $display("FAIL post_flags: cout=%b ovf=%b want 0 1", bus.cout, bus.ovf);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add_sub();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder/subtractor sequencer. It time-shares one full_adder_nand cell (ports a, b, cin, s, cout) across all WIDTH bit positions, one bit per clock, LSB first.
- Owns operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Sits between lab stimulus/control logic and the single-bit adder datapath. It is the team's first multi-cycle arithmetic controller.

Parameters:
- WIDTH, 8: operand/result width in bits, minimum 2.
- CNT_W, 3: bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result, registered.
- cout  output  1  final carry-out. For subtract, 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow flag.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Shift registers, carry flip-flop and counter are cleared. Reset has priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: load A_sh=op_a, B_sh = sub ? ~op_b : op_b, carry = sub ? 1 : cin, cnt=0. Next state RUN.
- IDLE, start=0: remain in IDLE.
- RUN, every cycle:
  - Full adder inputs are a=A_sh[0], b=B_sh[0], cin=carry.
  - S_sh shifts right with fa.s entering at the MSB.
  - A_sh and B_sh shift right.
  - carry <= fa.cout; cnt <= cnt+1.
- RUN, last bit (cnt==WIDTH-1): capture last_cin = carry (the carry into the MSB). Next state DONE.
- DONE: lasts exactly one cycle, then IDLE.
  - On entering DONE: sum <= final S_sh, cout <= carry, ovf <= carry ^ last_cin.
- busy is registered and equals (state==RUN): high for exactly WIDTH cycles.
- done is registered and equals (state==DONE): high for exactly 1 cycle.
- Latency: start sampled at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1. sum, cout and ovf are valid in the same cycle done is high.
- sum, cout and ovf hold their previous values through IDLE and RUN. They change only on entry to DONE or on reset.
- start while in RUN or DONE: ignored, not queued. Operand inputs are don't-care outside the sampling edge.
- start held continuously: back-to-back operations, one IDLE cycle between, so the period is WIDTH+2 cycles.
- Reset mid-RUN: abort immediately to IDLE. No done pulse; outputs go to 0.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, add, 0x5A+0x3C, cin=0 → busy high 8 cycles; done high in cycle 9 after start; sum=0x96, cout=0, ovf=1.
- Add 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then add 0x00+0x00, cin=1 → sum=0x01, cout=0, ovf=0.
- Subtract 0x10-0x20 (cin=1, ignored) → sum=0xF0, cout=0, ovf=0. Subtract 0x80-0x01 → sum=0x7F, cout=1, ovf=1.
- start pulsed again during RUN with different operands → ignored; first result unchanged; exactly one done pulse. start held high for 25 cycles → done pulses at cycles 9 and 19 after the first sample; outputs stable between pulses.
- Start 0x5A+0x3C, assert rst in the 4th RUN cycle → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. done never pulses. A new start after reset completes normally.
